// File: rtl/instr_encode_loader.sv
// Boot-time loader: encodes symbolic LW/SW/R/BEQ fields into RV32I words and writes them to imem.
// Latency: fields accepted on edge N appear as imem_we/addr/wdata during cycle N+1; one word per 2 cycles.
// Backpressure: in_ready is high only in LOAD; WRITE and DONE stall the host until the write or a restart.
module instr_encode_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_kind,
    input  logic [2:0]            in_func3,
    input  logic [6:0]            in_func7,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [12:0]           in_imm,
    input  logic                  in_last,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] KIND_LW  = 2'b00;
    localparam logic [1:0] KIND_SW  = 2'b01;
    localparam logic [1:0] KIND_R   = 2'b10;
    localparam logic [1:0] KIND_BEQ = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] BASE     = BASE_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    // count value just before the memory is full: the write seen here is the last one that fits
    localparam logic [ADDR_WIDTH:0]   CNT_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t      state_q;
    state_t      state_d;
    logic        last_q;
    logic        accept;
    logic        at_capacity;
    logic [31:0] enc_word;
    logic        enc_err;

    assign accept      = in_valid && in_ready;
    assign at_capacity = (count == CNT_LAST);

    // Encode the presented fields; enc_err flags an immediate that cannot be represented
    always_comb begin
        enc_word = 32'd0;
        enc_err  = 1'b0;
        case (in_kind)
            KIND_LW: begin
                enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
                enc_err  = (in_imm[12] != in_imm[11]);
            end
            KIND_SW: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
                enc_err  = (in_imm[12] != in_imm[11]);
            end
            KIND_R: begin
                enc_word = {in_func7, in_rs2, in_rs1, in_func3, in_rd, 7'b0110011};
            end
            KIND_BEQ: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                            in_imm[4:1], in_imm[11], 7'b1100011};
                enc_err  = in_imm[0];
            end
            default: begin
                enc_word = 32'd0;
                enc_err  = 1'b0;
            end
        endcase
    end

    // State register; async reset drops a pending write strobe immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/strobe outputs, all decoded from the current state
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        imem_we  = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                imem_we = 1'b1;
                if (last_q || at_capacity) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (restart) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Datapath: capture the word on accept, advance address/count on the write edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_addr  <= BASE;
            imem_wdata <= 32'd0;
            count      <= '0;
            error      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        imem_wdata <= enc_word;
                        last_q     <= in_last;
                        if (enc_err) begin
                            error <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    count <= count + CNT_ONE;
                    // hold the address on the final slot so it never wraps
                    if (!at_capacity) begin
                        imem_addr <= imem_addr + ADDR_ONE;
                    end else if (!last_q) begin
                        error <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (restart) begin
                        imem_addr <= BASE;
                        count     <= '0;
                        error     <= 1'b0;
                    end
                end
                default: begin
                    last_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: scoreboard of expected imem writes plus state checks.
// Two instances share the stimulus: a 64-word loader and a 4-word one for the capacity case.
// Every wait on the DUT is bounded; the run always reaches the summary line.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_kind;
    logic [2:0]  in_func3;
    logic [6:0]  in_func7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [12:0] in_imm;
    logic        in_last;
    logic        restart;

    logic        in_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;
    logic        done;
    logic        error;

    logic        in_ready2;
    logic        imem_we2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wdata2;
    logic [2:0]  count2;
    logic        done2;
    logic        error2;

    int n_assert = 0;
    int n_fail   = 0;
    logic [37:0] sb[$];

    always #5 clk = ~clk;

    instr_encode_loader #(.ADDR_WIDTH(6), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_func3(in_func3), .in_func7(in_func7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .restart(restart), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
        .done(done), .error(error)
    );

    instr_encode_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_kind(in_kind), .in_func3(in_func3), .in_func7(in_func7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .restart(restart), .imem_we(imem_we2),
        .imem_addr(imem_addr2), .imem_wdata(imem_wdata2), .count(count2),
        .done(done2), .error(error2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe of the 64-word loader must match the oldest expected word
    always @(negedge clk) begin
        if (rst === 1'b0 && imem_we === 1'b1) begin
            chk("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                logic [37:0] e;
                e = sb.pop_front();
                chk("sb_addr", 64'(imem_addr), 64'(e[37:32]));
                chk("sb_wdata", 64'(imem_wdata), 64'(e[31:0]));
            end
        end
    end

    // Present one instruction, check the one-cycle write latency, leave at negedge of cycle N+1
    task automatic send(input logic [1:0] k, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [12:0] imm, input logic last,
                        input logic [5:0] exp_addr, input logic [31:0] exp_word);
        int t;
        @(negedge clk);
        in_kind  = k;   in_func3 = f3;  in_func7 = f7;
        in_rd    = rd;  in_rs1   = rs1; in_rs2   = rs2;
        in_imm   = imm; in_last  = last;
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ready_for_accept", 64'(in_ready), 64'd1);
        sb.push_back({exp_addr, exp_word});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // scramble fields: the loader must have sampled them on the accept edge
        in_kind  = 2'($urandom);  in_func3 = 3'($urandom); in_func7 = 7'($urandom);
        in_rd    = 5'($urandom);  in_rs1   = 5'($urandom); in_rs2   = 5'($urandom);
        in_imm   = 13'($urandom); in_last  = 1'b0;
        chk("ready_low_in_write", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("we_at_n_plus_1", 64'(imem_we), 64'd1);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; restart = 1'b0; in_last = 1'b0;
        in_kind = 2'd0; in_func3 = 3'd0; in_func7 = 7'd0;
        in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 13'd0;
        #2;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_we", 64'(imem_we), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // add x3,x1,x2
        send(2'b10, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 6'd0, 32'h002081B3);
        @(negedge clk);
        chk("r_we_one_cycle", 64'(imem_we), 64'd0);
        chk("r_count", 64'(count), 64'd1);
        chk("r_ready_back", 64'(in_ready), 64'd1);

        // lw x5,8(x0) ; sw x5,12(x0)
        send(2'b00, 3'd7, 7'h7F, 5'd5, 5'd0, 5'd0, 13'd8, 1'b0, 6'd1, 32'h00802283);
        send(2'b01, 3'd7, 7'h7F, 5'd0, 5'd0, 5'd5, 13'd12, 1'b0, 6'd2, 32'h00502623);
        @(negedge clk);
        chk("lwsw_count", 64'(count), 64'd3);
        chk("lwsw_no_error", 64'(error), 64'd0);

        // beq x1,x2,-8 as the final instruction
        send(2'b11, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1, 6'd3, 32'hFE208CE3);
        @(negedge clk);
        chk("beq_done", 64'(done), 64'd1);
        chk("beq_ready_low", 64'(in_ready), 64'd0);
        chk("beq_count", 64'(count), 64'd4);
        chk("beq_no_error", 64'(error), 64'd0);

        pulse_restart();
        chk("restart_count", 64'(count), 64'd0);
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_ready", 64'(in_ready), 64'd1);
        chk("restart_addr", 64'(imem_addr), 64'd0);

        // LW with imm out of 12-bit range: flagged, word still written
        send(2'b00, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'h0800, 1'b0, 6'd0, 32'h80002083);
        @(negedge clk);
        chk("lw_range_error", 64'(error), 64'd1);
        chk("lw_range_count", 64'(count), 64'd1);

        // restart outside DONE has no effect
        pulse_restart();
        chk("restart_ignored_count", 64'(count), 64'd1);
        chk("restart_ignored_error", 64'(error), 64'd1);

        // BEQ with odd offset: bit 0 dropped and flagged
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_error", 64'(error), 64'd0);
        send(2'b11, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'h0005, 1'b0, 6'd0, 32'h00208263);
        @(negedge clk);
        chk("beq_odd_error", 64'(error), 64'd1);

        // reset asserted while a write strobe is up
        @(negedge clk);
        in_kind = 2'b00; in_rd = 5'd7; in_rs1 = 5'd0; in_imm = 13'd4; in_last = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("midwrite_we_before", 64'(imem_we), 64'd1);
        rst = 1'b1;
        #1;
        chk("midwrite_we_killed", 64'(imem_we), 64'd0);
        chk("midwrite_count", 64'(count), 64'd0);
        chk("midwrite_error", 64'(error), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midwrite_ready_after", 64'(in_ready), 64'd1);
        chk("midwrite_count_after", 64'(count), 64'd0);
        chk("midwrite_no_we_after", 64'(imem_we), 64'd0);

        // capacity: four words without in_last fill the 4-word loader
        send(2'b10, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0, 6'd0, 32'h003100B3);
        send(2'b10, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0, 6'd1, 32'h003100B3);
        send(2'b10, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0, 6'd2, 32'h003100B3);
        chk("cap_not_done_early", 64'(done2), 64'd0);
        send(2'b10, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0, 6'd3, 32'h003100B3);
        chk("cap_last_addr", 64'(imem_addr2), 64'd3);
        @(negedge clk);
        chk("cap_done", 64'(done2), 64'd1);
        chk("cap_error", 64'(error2), 64'd1);
        chk("cap_count", 64'(count2), 64'd4);
        chk("cap_ready_low", 64'(in_ready2), 64'd0);
        chk("cap_big_not_done", 64'(done), 64'd0);

        pulse_restart();
        chk("cap_restart_count", 64'(count2), 64'd0);
        chk("cap_restart_done", 64'(done2), 64'd0);
        chk("cap_restart_error", 64'(error2), 64'd0);
        chk("cap_restart_addr", 64'(imem_addr2), 64'd0);
        chk("cap_restart_ready", 64'(in_ready2), 64'd1);
        chk("cap_big_count_kept", 64'(count), 64'd4);

        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
